// File: rtl/spi_xfer_queue_if.sv
// Host and SPI-master handshake bundle for spi_xfer_queue.
// The slave modport is the queue itself; master is whoever drives the host and engine side.
interface spi_xfer_queue_if #(
  parameter int unsigned AW = 3
) ();
  logic          en;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_full;
  logic [AW:0]   tx_count;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic [AW:0]   rx_count;
  logic          wr_err;
  logic          rd_err;
  logic          clr_err;
  logic          xfer_active;
  logic          m_start;
  logic [7:0]    m_tx_data;
  logic          m_busy;
  logic [7:0]    m_rx_data;

  modport slave (
    input  en, wr_en, wr_data, rd_en, clr_err, m_busy, m_rx_data,
    output tx_full, tx_count, rd_data, rx_empty, rx_count, wr_err, rd_err,
           xfer_active, m_start, m_tx_data
  );

  modport master (
    output en, wr_en, wr_data, rd_en, clr_err, m_busy, m_rx_data,
    input  tx_full, tx_count, rd_data, rx_empty, rx_count, wr_err, rd_err,
           xfer_active, m_start, m_tx_data
  );
endinterface

// File: rtl/spi_xfer_queue.sv
// TX/RX byte FIFOs around an 8-bit SPI master: one master transfer per TX byte,
// each received byte lands in the RX FIFO in strict order.
module spi_xfer_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  spi_xfer_queue_if.slave  bus
);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    STORE     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      tx_mem [DEPTH];
  logic [7:0]      rx_mem [DEPTH];
  logic [AW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]      m_tx_data_q, m_tx_data_d, rx_byte_q, rx_byte_d;
  logic            wr_err_q, wr_err_d, rd_err_q, rd_err_d;

  logic tx_full_c, rx_empty_c, launch_ok_c;
  logic launch_c, capture_c, store_c, m_start_c, xfer_active_c;
  logic tx_push_c, rx_pop_c;

  assign tx_full_c   = (tx_cnt_q == CW'(DEPTH));
  assign rx_empty_c  = (rx_cnt_q == '0);
  // RX space is reserved here so the later STORE push can never overflow.
  assign launch_ok_c = bus.en && (tx_cnt_q != '0) && (rx_cnt_q != CW'(DEPTH)) && !bus.m_busy;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (launch_ok_c) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (bus.m_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!bus.m_busy) state_d = STORE;
      STORE:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    launch_c      = 1'b0;
    capture_c     = 1'b0;
    store_c       = 1'b0;
    m_start_c     = 1'b0;
    xfer_active_c = (state_q != IDLE);
    case (state_q)
      IDLE:      launch_c  = launch_ok_c;
      LAUNCH:    m_start_c = 1'b1;
      WAIT_DONE: capture_c = !bus.m_busy;
      STORE:     store_c   = 1'b1;
      default:   ;
    endcase
  end

  // A write to a full TX is still taken when a launch frees a slot on the same edge.
  assign tx_push_c = bus.wr_en && (!tx_full_c || launch_c);
  assign rx_pop_c  = bus.rd_en && !rx_empty_c;

  always_comb begin
    tx_wptr_d   = tx_wptr_q;
    tx_rptr_d   = tx_rptr_q;
    rx_wptr_d   = rx_wptr_q;
    rx_rptr_d   = rx_rptr_q;
    m_tx_data_d = m_tx_data_q;
    rx_byte_d   = rx_byte_q;
    if (tx_push_c) tx_wptr_d = tx_wptr_q + AW'(1);
    if (launch_c) begin
      tx_rptr_d   = tx_rptr_q + AW'(1);
      m_tx_data_d = tx_mem[tx_rptr_q];
    end
    if (store_c)   rx_wptr_d = rx_wptr_q + AW'(1);
    if (rx_pop_c)  rx_rptr_d = rx_rptr_q + AW'(1);
    if (capture_c) rx_byte_d = bus.m_rx_data;
    tx_cnt_d = tx_cnt_q + CW'(tx_push_c) - CW'(launch_c);
    rx_cnt_d = rx_cnt_q + CW'(store_c) - CW'(rx_pop_c);
    // A new error outranks a same-cycle clear.
    wr_err_d = (bus.wr_en && tx_full_c && !launch_c) || (wr_err_q && !bus.clr_err);
    rd_err_d = (bus.rd_en && rx_empty_c) || (rd_err_q && !bus.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      m_tx_data_q <= '0;
      rx_byte_q   <= '0;
      wr_err_q    <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      m_tx_data_q <= m_tx_data_d;
      rx_byte_q   <= rx_byte_d;
      wr_err_q    <= wr_err_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // Storage arrays carry no reset; occupancy counts define validity.
  always_ff @(posedge clk) begin
    if (tx_push_c) tx_mem[tx_wptr_q] <= bus.wr_data;
    if (store_c)   rx_mem[rx_wptr_q] <= rx_byte_q;
  end

  assign bus.tx_full     = tx_full_c;
  assign bus.tx_count    = tx_cnt_q;
  assign bus.rx_empty    = rx_empty_c;
  assign bus.rx_count    = rx_cnt_q;
  assign bus.rd_data     = rx_empty_c ? 8'h00 : rx_mem[rx_rptr_q];
  assign bus.wr_err      = wr_err_q;
  assign bus.rd_err      = rd_err_q;
  assign bus.xfer_active = xfer_active_c;
  assign bus.m_start     = m_start_c;
  assign bus.m_tx_data   = m_tx_data_q;
endmodule

// File: tb/tb_spi_xfer_queue.sv
// Scoreboard bench for spi_xfer_queue with a behavioural SPI master model;
// launches and host reads are checked by a monitor against FIFO-order queues.
module tb_spi_xfer_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_queue_if #(.AW(AW)) bus ();
  spi_xfer_queue #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_start = 0;
  int xfer_len = 5;
  bit rand_len = 1'b0;
  int slave_mode = 0;
  logic [7:0] key = 8'h00;
  bit spacing_on = 1'b0;
  bit last_valid = 1'b0;
  int last_cyc = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] slave_fn(input logic [7:0] b);
    case (slave_mode)
      0:       return b;
      1:       return ~b;
      default: return b ^ key;
    endcase
  endfunction

  // Behavioural SPI master: busy rises the edge after m_start, stays high for the
  // transfer length, and the received byte is valid when busy falls.
  logic       m_busy_q;
  logic [7:0] m_rx_q, m_sh_q;
  int         m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy_q <= 1'b0;
      m_rx_q   <= 8'h00;
      m_sh_q   <= 8'h00;
      m_cnt    <= 0;
    end else if (m_busy_q) begin
      if (m_cnt == 1) begin
        m_busy_q <= 1'b0;
        m_rx_q   <= slave_fn(m_sh_q);
      end
      m_cnt <= m_cnt - 1;
    end else if (bus.m_start) begin
      m_busy_q <= 1'b1;
      m_cnt    <= rand_len ? int'($urandom_range(1, 8)) : xfer_len;
      m_sh_q   <= bus.m_tx_data;
    end
  end
  assign bus.m_busy    = m_busy_q;
  assign bus.m_rx_data = m_rx_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_start) begin
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL launch_unexpected: m_tx_data=0x%02h with no pending byte", bus.m_tx_data);
        end else begin
          check("launch_byte", 32'(bus.m_tx_data), 32'(exp_tx.pop_front()));
        end
        if (spacing_on && last_valid)
          check("start_spacing", 32'(cyc - last_cyc), 32'(xfer_len + 4));
        last_cyc   = cyc;
        last_valid = 1'b1;
        n_start++;
      end
      if (bus.rd_en && !bus.rx_empty) begin
        if (exp_rx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: rd_data=0x%02h with nothing expected", bus.rd_data);
        end else begin
          check("rx_byte", 32'(bus.rd_data), 32'(exp_rx.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accept) begin
      exp_tx.push_back(b);
      exp_rx.push_back(slave_fn(b));
    end
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wr_room(input logic [7:0] b);
    for (int i = 0; i < 200 && bus.tx_full; i++) tick();
    check("wr_room_timeout", 32'(bus.tx_full), 32'd0);
    wr(b, 1'b1);
  endtask

  task automatic rd();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int max, input string nm);
    for (int i = 0; i < max && int'(bus.rx_count) != n; i++) tick();
    check(nm, 32'(bus.rx_count), 32'(n));
  endtask

  task automatic drain(input string nm);
    bus.en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (exp_rx.size() == 0 && bus.rx_empty && bus.tx_count == '0 && !bus.xfer_active) break;
      if (!bus.rx_empty) rd();
      else tick();
    end
    check({nm, "_rx_empty"}, 32'(bus.rx_empty), 32'd1);
    check({nm, "_tx_count"}, 32'(bus.tx_count), 32'd0);
    check({nm, "_sb_left"}, 32'(exp_rx.size()), 32'd0);
  endtask

  int n0;
  initial begin
    bus.en = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 8'h00;
    bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("rst_tx_count", 32'(bus.tx_count), 32'd0);
    check("rst_rx_count", 32'(bus.rx_count), 32'd0);
    check("rst_tx_full", 32'(bus.tx_full), 32'd0);
    check("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_wr_err", 32'(bus.wr_err), 32'd0);
    check("rst_rd_err", 32'(bus.rd_err), 32'd0);
    check("rst_m_start", 32'(bus.m_start), 32'd0);
    check("rst_m_tx_data", 32'(bus.m_tx_data), 32'd0);
    check("rst_xfer_active", 32'(bus.xfer_active), 32'd0);

    // Single byte, loopback
    slave_mode = 0; xfer_len = 5; n0 = n_start;
    bus.en = 1'b1;
    wr(8'hA5, 1'b1);
    wait_rx(1, 60, "single_rx_count");
    check("single_starts", 32'(n_start - n0), 32'd1);
    check("single_rd_data", 32'(bus.rd_data), 32'hA5);
    rd();
    check("single_rx_empty", 32'(bus.rx_empty), 32'd1);

    // Burst 0x01..0x08 with inverting slave and launch spacing checks
    slave_mode = 1; bus.en = 1'b0;
    for (int i = 1; i <= 8; i++) wr(8'(i), 1'b1);
    check("burst_tx_full", 32'(bus.tx_full), 32'd1);
    check("burst_tx_count", 32'(bus.tx_count), 32'd8);
    n0 = n_start; last_valid = 1'b0; spacing_on = 1'b1;
    bus.en = 1'b1;
    wait_rx(8, 300, "burst_rx_count");
    check("burst_starts", 32'(n_start - n0), 32'd8);
    spacing_on = 1'b0;
    drain("burst");

    // RX back-pressure with two bytes left in TX
    slave_mode = 0; n0 = n_start;
    for (int i = 0; i < 10; i++) wr_room(8'($urandom));
    wait_rx(8, 400, "bp_rx_full");
    repeat (3 * (xfer_len + 4)) tick();
    check("bp_starts_held", 32'(n_start - n0), 32'd8);
    check("bp_tx_count", 32'(bus.tx_count), 32'd2);
    rd();
    repeat (xfer_len + 10) tick();
    check("bp_one_more_start", 32'(n_start - n0), 32'd9);
    check("bp_tx_count_after", 32'(bus.tx_count), 32'd1);
    check("bp_rx_count_after", 32'(bus.rx_count), 32'd8);
    drain("bp");

    // Sticky errors
    bus.en = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'($urandom), 1'b1);
    check("err_tx_full", 32'(bus.tx_full), 32'd1);
    wr(8'hEE, 1'b0);
    check("err_wr_err", 32'(bus.wr_err), 32'd1);
    check("err_tx_count", 32'(bus.tx_count), 32'd8);
    rd();
    check("err_rd_err", 32'(bus.rd_err), 32'd1);
    bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
    check("clr_wr_err", 32'(bus.wr_err), 32'd0);
    check("clr_rd_err", 32'(bus.rd_err), 32'd0);
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.rd_en = 1'b1; bus.clr_err = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    check("clr_vs_new_wr_err", 32'(bus.wr_err), 32'd1);
    check("clr_vs_new_rd_err", 32'(bus.rd_err), 32'd1);
    bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
    check("clr2_errs", 32'({bus.wr_err, bus.rd_err}), 32'd0);

    // Enable held low, then raised together with a write to full TX
    n0 = n_start;
    repeat (10) tick();
    check("en0_no_start", 32'(n_start - n0), 32'd0);
    bus.en = 1'b1;
    wr(8'h3C, 1'b1);
    check("sim_tx_count", 32'(bus.tx_count), 32'd8);
    check("sim_wr_err", 32'(bus.wr_err), 32'd0);
    drain("sim");

    // Randomised traffic with random transfer lengths and enable gaps
    slave_mode = 2; key = 8'($urandom); rand_len = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      bus.wr_en = !bus.tx_full && ($urandom_range(0, 1) == 1);
      bus.wr_data = 8'($urandom);
      if (bus.wr_en) begin
        exp_tx.push_back(bus.wr_data);
        exp_rx.push_back(slave_fn(bus.wr_data));
      end
      bus.rd_en = !bus.rx_empty && ($urandom_range(0, 2) != 0);
      tick();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    end
    drain("rand");
    check("rand_errs", 32'({bus.wr_err, bus.rd_err}), 32'd0);
    rand_len = 1'b0;

    // Async reset in the middle of a transfer
    slave_mode = 0; xfer_len = 20; bus.en = 1'b0;
    for (int i = 0; i < 3; i++) wr(8'($urandom), 1'b1);
    bus.en = 1'b1;
    for (int i = 0; i < 20 && !bus.m_busy; i++) tick();
    check("rst_mid_busy_seen", 32'(bus.m_busy), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    exp_tx.delete(); exp_rx.delete();
    #1;
    check("rst_mid_tx_count", 32'(bus.tx_count), 32'd0);
    check("rst_mid_rx_empty", 32'(bus.rx_empty), 32'd1);
    check("rst_mid_m_start", 32'(bus.m_start), 32'd0);
    check("rst_mid_xfer_active", 32'(bus.xfer_active), 32'd0);
    n0 = n_start;
    tick();
    rst = 1'b0;
    repeat (40) tick();
    check("rst_mid_no_push", 32'(bus.rx_count), 32'd0);
    check("rst_mid_no_start", 32'(n_start - n0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end
endmodule
